// File: rtl/vga_line_fetch.sv
// Double-buffered scanline prefetcher: while one row is displayed from one line buffer,
// the next row is fetched over a req/ack port into the other; pixel reads are registered (1 cycle).
module vga_line_fetch #(
  parameter int          H_PIXELS = 640,
  parameter int          V_LINES  = 480,
  parameter logic [31:0] FB_BASE  = 32'h0
) (
  input  logic        iClk_50,
  input  logic        iRst,
  input  logic [31:0] iVGA_colorAddress,
  output logic [29:0] oVGA_colorData,
  output logic [31:0] oMem_Addr,
  output logic        oMem_Req,
  input  logic        iMem_Ack,
  input  logic [31:0] iMem_Data,
  output logic        oBusy,
  output logic        oUnderrun
);

  localparam int            CW       = $clog2(H_PIXELS);
  localparam logic [15:0]   H16      = 16'(H_PIXELS);
  localparam logic [15:0]   V16      = 16'(V_LINES);
  localparam logic [CW-1:0] COL_LAST = CW'(H_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, START, REQ, DONE} state_e;

  state_e          state_q;
  logic [15:0]     last_y_q;
  logic [15:0]     tgt_q;
  logic [15:0]     pend_q;
  logic            pend_vld_q;
  logic            boot_q;
  logic [CW-1:0]   col_q;
  logic [31:0]     addr_q;
  logic [1:0]      valid_q;
  logic [1:0][15:0] tag_q;
  logic            req_q;
  logic            busy_q;
  logic            underrun_q;
  logic            hit_q;
  logic [29:0]     rd_q;
  logic [29:0]     lbuf [2][H_PIXELS];

  logic [15:0] y, x;
  logic        hit;
  logic        row_chg;
  logic [15:0] row_tgt_d;
  logic        launch_d;
  logic [15:0] launch_tgt_d;
  logic        unused_hi_bits;

  assign y              = iVGA_colorAddress[31:16];
  assign x              = iVGA_colorAddress[15:0];
  assign unused_hi_bits = &iMem_Data[31:30];

  always_comb begin
    hit          = valid_q[y[0]] && (tag_q[y[0]] == y) && (x < H16);
    row_chg      = (y != last_y_q) && (y < V16);
    row_tgt_d    = (y == V16 - 16'd1) ? 16'd0 : y + 16'd1;
    launch_d     = (state_q == IDLE) && (boot_q || row_chg || pend_vld_q);
    // After reset row 0 is fetched first; a newly seen row outranks an older pending one.
    launch_tgt_d = boot_q ? 16'd0 : (row_chg ? row_tgt_d : pend_q);
  end

  // Line buffer storage: no reset, output masked by hit_q instead.
  always_ff @(posedge iClk_50) begin
    if (!iRst && state_q == REQ && iMem_Ack) begin
      lbuf[tgt_q[0]][col_q] <= iMem_Data[29:0];
    end
    rd_q <= lbuf[y[0]][x[CW-1:0]];
  end

  always_ff @(posedge iClk_50) begin
    if (iRst) begin
      state_q    <= IDLE;
      last_y_q   <= 16'hFFFF;
      tgt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      boot_q     <= 1'b1;
      col_q      <= '0;
      addr_q     <= '0;
      valid_q    <= '0;
      tag_q      <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      hit_q <= hit;
      if ((x < H16) && (y < V16) && !hit) underrun_q <= 1'b1;
      if (row_chg) last_y_q <= y;
      if (row_chg && state_q != IDLE) begin
        pend_vld_q <= 1'b1;
        pend_q     <= row_tgt_d;
      end

      case (state_q)
        IDLE: begin
          if (launch_d) begin
            boot_q                  <= 1'b0;
            tgt_q                   <= launch_tgt_d;
            valid_q[launch_tgt_d[0]] <= 1'b0;
            tag_q[launch_tgt_d[0]]  <= launch_tgt_d;
            busy_q                  <= 1'b1;
            state_q                 <= START;
            // A row change landing on the boot cycle is kept for the next fetch.
            pend_vld_q              <= boot_q && row_chg;
            if (boot_q && row_chg) pend_q <= row_tgt_d;
          end
        end
        START: begin
          col_q   <= '0;
          addr_q  <= FB_BASE + (({16'd0, tgt_q} * 32'(H_PIXELS)) << 2);
          req_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: begin
          if (iMem_Ack) begin
            if (col_q == COL_LAST) begin
              req_q   <= 1'b0;
              state_q <= DONE;
            end else begin
              col_q  <= col_q + CW'(1);
              addr_q <= addr_q + 32'd4;
            end
          end
        end
        DONE: begin
          valid_q[tgt_q[0]] <= 1'b1;
          busy_q            <= 1'b0;
          state_q           <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oVGA_colorData = hit_q ? rd_q : 30'd0;
  assign oMem_Addr      = addr_q;
  assign oMem_Req       = req_q;
  assign oBusy          = busy_q;
  assign oUnderrun      = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Bench for vga_line_fetch: randomized reads and memory acks against a row-level model.
module tb_vga_line_fetch;

  localparam int          H    = 640;
  localparam int          V    = 480;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        iRst = 1'b1;
  logic [31:0] iVGA_colorAddress = 32'hFFFF_0000;
  logic [29:0] oVGA_colorData;
  logic [31:0] oMem_Addr;
  logic        oMem_Req;
  logic        iMem_Ack = 1'b0;
  logic [31:0] iMem_Data = 32'd0;
  logic        oBusy;
  logic        oUnderrun;

  vga_line_fetch dut (
    .iClk_50          (clk),
    .iRst             (iRst),
    .iVGA_colorAddress(iVGA_colorAddress),
    .oVGA_colorData   (oVGA_colorData),
    .oMem_Addr        (oMem_Addr),
    .oMem_Req         (oMem_Req),
    .iMem_Ack         (iMem_Ack),
    .iMem_Data        (iMem_Data),
    .oBusy            (oBusy),
    .oUnderrun        (oUnderrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: what each buffer holds, last row seen, active and pending fetch targets.
  bit m_valid [2];
  int m_tag   [2];
  int m_last;
  int m_active;
  int m_pend;
  bit m_und;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] pix(input int row, input int col);
    return 30'(row * 1000 + col);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    iVGA_colorAddress = 32'hFFFF_0000;
  endtask

  task automatic model_reset();
    m_valid[0] = 0; m_valid[1] = 0;
    m_tag[0] = -1;  m_tag[1] = -1;
    m_last = -1;
    m_active = 0;
    m_pend = -1;
    m_und = 0;
  endtask

  task automatic rd(input int y, input int x);
    bit hit;
    logic [29:0] exp;
    int t;
    iVGA_colorAddress = {16'(y), 16'(x)};
    hit = m_valid[y & 1] && m_tag[y & 1] == y && x < H;
    exp = hit ? pix(y, x) : 30'd0;
    if (x < H && y < V && !hit) m_und = 1;
    step();
    chk("pix", oVGA_colorData, exp);
    chk("underrun", oUnderrun, m_und);
    if (y < V && y != m_last) begin
      m_last = y;
      t = (y == V - 1) ? 0 : y + 1;
      if (m_active < 0) begin
        m_active = t;
        m_valid[t & 1] = 0;
      end else begin
        m_pend = t;
      end
    end
  endtask

  // Plays the frame-buffer memory for one row fetch; returns early after a reset abort.
  task automatic serve(input int tgt, input int ack_pct, input int stall,
                       input int abort_at, output bit aborted);
    int k = 0;
    int cyc = 0;
    int stalled = 0;
    bit ack;
    logic [31:0] off;
    int p;
    aborted = 0;
    while (!(k == H && !oBusy) && cyc < 5000) begin
      ack = 0;
      if (oMem_Req) begin
        chk("req_addr", oMem_Addr, BASE + 32'((tgt * H + k) * 4));
        if (stalled < stall) stalled++;
        else ack = ($urandom_range(99) < ack_pct);
      end
      off = oMem_Addr - BASE;
      p = int'(off >> 2);
      iMem_Ack = ack;
      iMem_Data = {2'($urandom), pix(p / H, p % H)};
      step();
      cyc++;
      if (oMem_Req && !ack && stalled > 0 && stalled <= stall && k == 0)
        chk("stall_req", oMem_Req, 1);
      if (ack) begin
        k++;
        if (k == abort_at) begin
          iMem_Ack = 0;
          iRst = 1;
          step();
          chk("rst_req", oMem_Req, 0);
          chk("rst_busy", oBusy, 0);
          chk("rst_und", oUnderrun, 0);
          iRst = 0;
          aborted = 1;
          break;
        end
      end
    end
    iMem_Ack = 0;
    if (!aborted) begin
      chk("fetch_words", k, H);
      chk("fetch_in_time", cyc < 5000, 1);
    end
  endtask

  task automatic drain(input int pct, input int stall_first);
    int st = stall_first;
    int a;
    bit ab;
    park();
    while (m_active >= 0) begin
      a = m_active;
      serve(a, pct, st, -1, ab);
      st = 0;
      m_valid[a & 1] = 1;
      m_tag[a & 1] = a;
      if (m_pend >= 0) begin
        m_active = m_pend;
        m_pend = -1;
        m_valid[m_active & 1] = 0;
      end else begin
        m_active = -1;
      end
    end
    chk("idle_busy", oBusy, 0);
  endtask

  initial begin : main
    bit ab;
    int y, x, r;
    model_reset();

    iRst = 1;
    repeat (3) step();
    chk("rst_req", oMem_Req, 0);
    chk("rst_addr", oMem_Addr, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_und", oUnderrun, 0);
    chk("rst_pix", oVGA_colorData, 0);
    iRst = 0;

    drain(100, 0);
    rd(0, 5);
    rd(1, 0);
    drain(70, 10);

    rd(2, 7);
    rd(478, 3);
    drain(80, 0);
    rd(479, 10);
    drain(90, 0);
    rd(0, 639);
    rd(1, 640);
    drain(75, 2);

    rd(5, 0);
    park();
    serve(6, 100, 0, 300, ab);
    chk("aborted", ab, 1);
    model_reset();
    drain(100, 0);
    rd(0, 0);
    drain(85, 0);

    for (int it = 0; it < 16; it++) begin
      r = $urandom_range(9);
      if (r < 5 && m_valid[r & 1]) y = m_tag[r & 1];
      else if (r < 8) y = $urandom_range(V - 1);
      else y = V + $urandom_range(20);
      x = $urandom_range(699);
      rd(y, x);
      drain(60 + $urandom_range(40), $urandom_range(3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
